rdback_streamer: RTL
====================

// Module: rdback_streamer
// PURPOSE
//  Drains the two per-pseudo-channel read-back FIFOs (PC0/PC1, DQ_WIDTH-bit entries) downstream of
//  the SoftMC read capturer. Each entry is serialized into OUT_WIDTH-bit AXI-Stream beats toward the
//  host DMA engine, with round-robin arbitration between PCs. Each beat is tagged with its source PC.
// PARAMETERS
//  DQ_WIDTH   256  width of one read-back FIFO entry
//  OUT_WIDTH  64   width of one output stream beat; DQ_WIDTH % OUT_WIDTH == 0, ratio >= 2
//  CNT_WIDTH  32   width of per-PC entry counters
// PORTS
//  clk                    in   1          single clock, all logic rising-edge
//  rst                    in   1          asynchronous, active-high reset
//  rdback_fifo_empty_pc0  in   1          PC0 FIFO empty flag
//  rdback_fifo_empty_pc1  in   1          PC1 FIFO empty flag
//  rdback_data_pc0        in   DQ_WIDTH   PC0 FIFO dout (standard mode: valid the cycle after rd_en)
//  rdback_data_pc1        in   DQ_WIDTH   PC1 FIFO dout
//  rdback_fifo_rd_en_pc0  out  1          PC0 pop strobe
//  rdback_fifo_rd_en_pc1  out  1          PC1 pop strobe
//  m_axis_tdata           out  OUT_WIDTH  beat data
//  m_axis_tvalid          out  1          beat valid
//  m_axis_tready          in   1          sink ready
//  m_axis_tlast           out  1          last beat of one DQ_WIDTH entry
//  m_axis_tuser           out  1          source PC of the current entry (0/1)
//  clr_cnt                in   1          synchronous clear of both counters
//  entries_sent_pc0       out  CNT_WIDTH  entries fully streamed from PC0
//  entries_sent_pc1       out  CNT_WIDTH  entries fully streamed from PC1
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE. All outputs 0: rd_en_pc*, tvalid, tlast, tuser, tdata, counters.
//    The last-served pointer resets to PC1, so PC0 wins the first tie.
//  - Reset mid-entry: the partially sent entry is dropped and no further beats of it are emitted.
//    A popped-but-uncaptured entry is lost.
//  - FSM states: IDLE -> POP -> LOAD -> SEND -> IDLE.
//    IDLE: if any FIFO is non-empty, pick a PC and go to POP.
//      Both non-empty: pick the PC opposite the last-served pointer.
//      One non-empty: pick that PC.
//      Latch sel = picked PC.
//    POP: drive rd_en of sel high for exactly one cycle. No other cycle asserts rd_en.
//      The two rd_en outputs are never high together.
//    LOAD: capture the sel FIFO dout into the DQ_WIDTH shift register and set beat_idx = 0.
//      Go to SEND with tvalid=1, tdata = bits [OUT_WIDTH-1:0], tuser = sel.
//    SEND: on each tvalid&&tready, advance beat_idx; the next tdata is the next higher OUT_WIDTH slice.
//      Slices go LSB first. beat_idx width is clog2(DQ_WIDTH/OUT_WIDTH).
//      tlast = 1 exactly when beat_idx == DQ_WIDTH/OUT_WIDTH-1.
//      On handshake of the tlast beat: deassert tvalid, update the last-served pointer to sel,
//      increment entries_sent_pc<sel>, and return to IDLE.
//  - AXIS rule: while tvalid && !tready, tdata/tlast/tuser hold stable and tvalid stays high.
//    tvalid never depends combinationally on tready.
//  - Latency: empty falls in IDLE at cycle N -> rd_en high in N+1 -> dout captured at the end of N+2
//    -> first beat valid in N+3. With tready held at 1, one entry occupies DQ_WIDTH/OUT_WIDTH cycles
//    in SEND plus 3 overhead cycles.
//  - Empty flags are sampled only in IDLE. A FIFO going empty later does not affect an entry in flight.
//  - Counters wrap modulo 2^CNT_WIDTH.
//    clr_cnt has priority over a same-cycle increment; the result is 0.
// TESTING
//  1. Reset then one 256-bit word 0x..0004_..0003_..0002_..0001 in PC0, tready=1
//     -> exactly one rd_en_pc0 pulse; beats 1,2,3,4 with tlast only on the 4th; tuser=0;
//     entries_sent_pc0=1.
//  2. Both FIFOs hold 3 entries, tready=1 -> entry order PC0,PC1,PC0,PC1,PC0,PC1.
//     Final counters are 3 and 3. Never both rd_en high.
//  3. Random tready with ~50% low while streaming 2 entries -> tdata/tlast/tuser hold during stalls.
//     Exactly 8 beats; data matches the loaded entries.
//  4. Assert rst during beat 2 of an entry -> all outputs 0 next cycle. After release the next entry
//     starts at beat 0. The counter excludes the aborted entry.
//  5. Preload entries_sent_pc1 = 2^32-1 via traffic or force, then send one PC1 entry -> counter = 0.
//     clr_cnt in the same cycle as an increment -> 0.

Source files
------------

// File: rtl/rdback_streamer_if.sv
// AXI-Stream beat channel carrying read-back data toward the host DMA engine.
// tuser carries the source pseudo-channel of the entry the beat belongs to.
interface rdback_streamer_if #(
  parameter int OUT_WIDTH = 64
);
  logic [OUT_WIDTH-1:0] tdata;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic                 tuser;

  modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
  modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/rdback_streamer.sv
// Drains the PC0/PC1 read-back FIFOs round-robin and serializes each DQ_WIDTH entry
// into OUT_WIDTH AXI-Stream beats, LSB slice first, tagged with the source PC.
module rdback_streamer #(
  parameter int DQ_WIDTH  = 256,
  parameter int OUT_WIDTH = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdback_fifo_empty_pc0,
  input  logic                 rdback_fifo_empty_pc1,
  input  logic [DQ_WIDTH-1:0]  rdback_data_pc0,
  input  logic [DQ_WIDTH-1:0]  rdback_data_pc1,
  output logic                 rdback_fifo_rd_en_pc0,
  output logic                 rdback_fifo_rd_en_pc1,
  rdback_streamer_if.master    m_axis,
  input  logic                 clr_cnt,
  output logic [CNT_WIDTH-1:0] entries_sent_pc0,
  output logic [CNT_WIDTH-1:0] entries_sent_pc1
);

  localparam int RATIO = DQ_WIDTH / OUT_WIDTH;
  localparam int IDX_W = $clog2(RATIO);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

  state_t                state;
  logic                  sel;
  logic                  last_served;
  logic [DQ_WIDTH-1:0]   shreg;
  logic [IDX_W-1:0]      beat_idx;
  logic                  pick;
  logic [DQ_WIDTH-1:0]   load_word;

  // Both non-empty: alternate away from the last-served PC; otherwise take the non-empty one.
  always_comb begin
    pick = rdback_fifo_empty_pc0;
    if (!rdback_fifo_empty_pc0 && !rdback_fifo_empty_pc1) pick = ~last_served;
    load_word = sel ? rdback_data_pc1 : rdback_data_pc0;
  end

  // NOTE: every register here uses <= so all updates see pre-edge values, regardless of order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                 <= IDLE;
      sel                   <= 1'b0;
      last_served           <= 1'b1;
      shreg                 <= '0;
      beat_idx              <= '0;
      rdback_fifo_rd_en_pc0 <= 1'b0;
      rdback_fifo_rd_en_pc1 <= 1'b0;
      m_axis.tdata          <= '0;
      m_axis.tvalid         <= 1'b0;
      m_axis.tlast          <= 1'b0;
      m_axis.tuser          <= 1'b0;
      entries_sent_pc0      <= '0;
      entries_sent_pc1      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (!rdback_fifo_empty_pc0 || !rdback_fifo_empty_pc1) begin
            sel                   <= pick;
            rdback_fifo_rd_en_pc0 <= ~pick;
            rdback_fifo_rd_en_pc1 <= pick;
            state                 <= POP;
          end
        end
        POP: begin
          // FIFO dout becomes valid the cycle after the pop strobe, i.e. during LOAD.
          rdback_fifo_rd_en_pc0 <= 1'b0;
          rdback_fifo_rd_en_pc1 <= 1'b0;
          state                 <= LOAD;
        end
        LOAD: begin
          m_axis.tdata  <= load_word[OUT_WIDTH-1:0];
          shreg         <= load_word >> OUT_WIDTH;
          beat_idx      <= '0;
          m_axis.tvalid <= 1'b1;
          m_axis.tlast  <= 1'b0;
          m_axis.tuser  <= sel;
          state         <= SEND;
        end
        SEND: begin
          if (m_axis.tready) begin
            if (beat_idx == LAST_IDX) begin
              m_axis.tvalid <= 1'b0;
              m_axis.tlast  <= 1'b0;
              last_served   <= sel;
              if (sel) entries_sent_pc1 <= entries_sent_pc1 + CNT_WIDTH'(1);
              else     entries_sent_pc0 <= entries_sent_pc0 + CNT_WIDTH'(1);
              state         <= IDLE;
            end else begin
              m_axis.tdata <= shreg[OUT_WIDTH-1:0];
              shreg        <= shreg >> OUT_WIDTH;
              beat_idx     <= beat_idx + 1'b1;
              m_axis.tlast <= (beat_idx + 1'b1) == LAST_IDX;
            end
          end
        end
        default: state <= IDLE;
      endcase
      // NOTE: placed after the increments so the later non-blocking write wins the same edge.
      if (clr_cnt) begin
        entries_sent_pc0 <= '0;
        entries_sent_pc1 <= '0;
      end
    end
  end

endmodule
